// File: rtl/prim_count.sv
// Hardened saturating up/down counter. A redundant complement register is
// updated independently so any single-register upset shows up on err_o.
module prim_count #(
  parameter int              Width      = 2,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             set_i,
  input  logic [Width-1:0] set_cnt_i,
  input  logic             incr_en_i,
  input  logic             decr_en_i,
  input  logic [Width-1:0] step_i,
  input  logic             commit_i,
  output logic [Width-1:0] cnt_o,
  output logic [Width-1:0] cnt_after_commit_o,
  output logic             err_o
);

  logic [Width-1:0] cnt_q, cnt_inv_q;
  logic [Width-1:0] cnt_d, cnt_inv_d;
  logic             cnt_we;

  logic [Width:0]   cnt_sum, inv_sum;
  logic [Width-1:0] cnt_up, cnt_dn, inv_up, inv_dn;

  // Primary path: add saturates at all-ones, subtract saturates at zero.
  assign cnt_sum = {1'b0, cnt_q} + {1'b0, step_i};
  assign cnt_up  = cnt_sum[Width] ? '1 : cnt_sum[Width-1:0];
  assign cnt_dn  = (step_i <= cnt_q) ? (cnt_q - step_i) : '0;

  // Complement path mirrors the arithmetic in the opposite direction.
  assign inv_sum = {1'b0, cnt_inv_q} + {1'b0, step_i};
  assign inv_up  = inv_sum[Width] ? '1 : inv_sum[Width-1:0];
  assign inv_dn  = (step_i <= cnt_inv_q) ? (cnt_inv_q - step_i) : '0;

  always_comb begin
    cnt_d     = cnt_q;
    cnt_inv_d = cnt_inv_q;
    cnt_we    = 1'b0;
    if (clr_i) begin
      cnt_d     = ResetValue;
      cnt_inv_d = ~ResetValue;
      cnt_we    = 1'b1;
    end else if (set_i) begin
      cnt_d     = set_cnt_i;
      cnt_inv_d = ~set_cnt_i;
      cnt_we    = 1'b1;
    end else if (incr_en_i && !decr_en_i) begin
      cnt_d     = cnt_up;
      cnt_inv_d = inv_dn;
      cnt_we    = commit_i;
    end else if (decr_en_i && !incr_en_i) begin
      cnt_d     = cnt_dn;
      cnt_inv_d = inv_up;
      cnt_we    = commit_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= ResetValue;
      cnt_inv_q <= ~ResetValue;
    end else if (cnt_we) begin
      cnt_q     <= cnt_d;
      cnt_inv_q <= cnt_inv_d;
    end
  end

  assign cnt_o              = cnt_q;
  assign cnt_after_commit_o = cnt_d;
  assign err_o              = (cnt_q ^ cnt_inv_q) != '1;

endmodule

// File: tb/tb_prim_count.sv
// Scoreboard bench for prim_count (Width=8): a driver predicts each cycle's
// outputs with an integer model, a negedge monitor pops and compares them.
module tb_prim_count;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       set = 1'b0;
  logic [7:0] set_cnt = '0;
  logic       incr_en = 1'b0;
  logic       decr_en = 1'b0;
  logic [7:0] step = '0;
  logic       commit = 1'b0;
  logic [7:0] cnt;
  logic [7:0] cnt_after;
  logic       err;

  int tests_run = 0;
  int tests_failed = 0;
  int model_cnt = 0;

  typedef struct {
    int cnt;
    int after;
    bit chk_err;
  } exp_t;

  exp_t sb[$];

  prim_count #(.Width(8), .ResetValue(8'h00)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .clr_i              (clr),
    .set_i              (set),
    .set_cnt_i          (set_cnt),
    .incr_en_i          (incr_en),
    .decr_en_i          (decr_en),
    .step_i             (step),
    .commit_i           (commit),
    .cnt_o              (cnt),
    .cnt_after_commit_o (cnt_after),
    .err_o              (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Behavioural rule set: priority clear > set > exclusive incr/decr > hold.
  function automatic int modelNext(int c, bit c_clr, bit c_set, int c_set_cnt,
                                   bit c_inc, bit c_dec, int c_step);
    if (c_clr) return 0;
    if (c_set) return c_set_cnt;
    if (c_inc && !c_dec) return (c + c_step > 255) ? 255 : c + c_step;
    if (c_dec && !c_inc) return (c_step > c) ? 0 : c - c_step;
    return c;
  endfunction

  task automatic driveAndPredict(input bit d_clr, input bit d_set, input int d_set_cnt,
                                 input bit d_inc, input bit d_dec, input int d_step,
                                 input bit d_commit, input bit chk_err);
    exp_t e;
    int   nxt;
    clr     = d_clr;
    set     = d_set;
    set_cnt = 8'(d_set_cnt);
    incr_en = d_inc;
    decr_en = d_dec;
    step    = 8'(d_step);
    commit  = d_commit;
    nxt       = modelNext(model_cnt, d_clr, d_set, d_set_cnt, d_inc, d_dec, d_step);
    e.cnt     = model_cnt;
    e.after   = nxt;
    e.chk_err = chk_err;
    sb.push_back(e);
    if (d_clr || d_set || d_commit) model_cnt = nxt;
  endtask

  task automatic applyStimulus(input bit d_clr, input bit d_set, input int d_set_cnt,
                               input bit d_inc, input bit d_dec, input int d_step,
                               input bit d_commit);
    @(posedge clk);
    #1;
    driveAndPredict(d_clr, d_set, d_set_cnt, d_inc, d_dec, d_step, d_commit, 1'b1);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    checkOutput("scoreboard_drain", sb.size(), 0);
  endtask

  // Monitor: one scoreboard entry per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("cnt_o", int'(cnt), e.cnt);
        checkOutput("cnt_after_commit_o", int'(cnt_after), e.after);
        if (e.chk_err) checkOutput("err_o", int'(err), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r_clr, r_set, r_step;

    rst = 1'b1;
    #1;
    checkOutput("reset_cnt", int'(cnt), 0);
    checkOutput("reset_err", int'(err), 0);
    checkOutput("reset_after", int'(cnt_after), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_cnt = 0;

    // Scenario 1: three increments of 5.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 5, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // Scenario 2: saturation at both ends.
    applyStimulus(0, 1, 250, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 10, 1);
    applyStimulus(0, 0, 0, 0, 1, 200, 1);
    applyStimulus(0, 0, 0, 0, 1, 100, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // Scenario 3: priority of clear over set over incr/decr.
    applyStimulus(0, 1, 15, 0, 0, 0, 1);
    applyStimulus(1, 1, 7, 1, 0, 0, 1);
    applyStimulus(0, 1, 7, 0, 1, 1, 1);

    // Scenario 4: commit gating.
    applyStimulus(0, 0, 0, 1, 0, 3, 0);
    applyStimulus(0, 0, 0, 1, 0, 3, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // Scenario 5: both enables hold, then async reset mid-count.
    applyStimulus(0, 1, 20, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 1, 4, 1);
    applyStimulus(0, 0, 0, 0, 0, 4, 1);
    applyStimulus(0, 0, 0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    waitDrain();
    @(posedge clk);
    #2;
    checkOutput("pre_reset_cnt", int'(cnt), 20);
    rst = 1'b1;
    #1;
    checkOutput("async_reset_cnt", int'(cnt), 0);
    checkOutput("async_reset_err", int'(err), 0);
    #1;
    rst = 1'b0;
    model_cnt = 0;

    // Scenario 6: fault in the complement register, then repair by set.
    applyStimulus(0, 1, 20, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    waitDrain();
    @(posedge clk);
    #1;
    force dut.cnt_inv_q = 8'hEB ^ 8'h10;
    #1;
    checkOutput("fault_err", int'(err), 1);
    checkOutput("fault_cnt", int'(cnt), 20);
    release dut.cnt_inv_q;
    driveAndPredict(0, 1, 3, 0, 0, 0, 0, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // Randomized traffic with edge-heavy step values.
    for (int i = 0; i < 400; i++) begin
      r_clr  = $urandom_range(0, 29);
      r_set  = $urandom_range(0, 9);
      r_step = $urandom_range(0, 3);
      applyStimulus(r_clr == 0, r_set == 0, int'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    (r_step == 0) ? 0 : (r_step == 1) ? int'($urandom_range(200, 255))
                                                      : int'($urandom_range(1, 40)),
                    $urandom_range(0, 3) != 0);
    end
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
